// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains bytes from the async FIFO read port and packs PACK_COUNT of them into a keep-masked word
// behind a valid/ready output; partial words leave on Flush or after TIMEOUT idle cycles.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_COUNT = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                             R_CLK,
    input  logic                             R_rst_n,
    input  logic                             Empty,
    input  logic [DATA_WIDTH-1:0]            R_Data,
    output logic                             R_inc,
    input  logic                             Flush,
    output logic [DATA_WIDTH*PACK_COUNT-1:0] Out_Data,
    output logic [PACK_COUNT-1:0]            Out_Keep,
    output logic                             Out_Valid,
    input  logic                             Out_Ready
);
    localparam int IW = $clog2(PACK_COUNT);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] LAST = IW'(PACK_COUNT - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    typedef enum logic {COLLECT, HOLD} state_t;
    state_t state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    assign R_inc = R_rst_n & (state == COLLECT) & ~Empty;
    always_ff @(posedge R_CLK) begin
        if (!R_rst_n) begin
            state     <= COLLECT;
            idx       <= '0;
            cnt       <= '0;
            Out_Valid <= 1'b0;
            Out_Data  <= '0;
            Out_Keep  <= '0;
        end else if (state == HOLD) begin
            if (Out_Ready) begin
                state     <= COLLECT;
                idx       <= '0;
                cnt       <= '0;
                Out_Valid <= 1'b0;
                Out_Data  <= '0;
                Out_Keep  <= '0;
            end
        end else if (R_inc) begin
            for (int i = 0; i < PACK_COUNT; i++)
                if (IW'(i) == idx) begin
                    Out_Data[i*DATA_WIDTH +: DATA_WIDTH] <= R_Data;
                    Out_Keep[i] <= 1'b1;
                end
            cnt <= '0;
            // idx is left at its last value on entering HOLD; the handshake clears it
            if (idx == LAST || Flush) begin
                state     <= HOLD;
                Out_Valid <= 1'b1;
            end else begin
                idx <= idx + IW'(1);
            end
        end else if (idx != '0) begin
            if (Flush || (TIMEOUT != 0 && cnt == CNT_LAST)) begin
                state     <= HOLD;
                Out_Valid <= 1'b1;
                cnt       <= '0;
            end else if (TIMEOUT != 0) begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed scenarios for fifo_rd_packer with hand-computed expectations.
module tb_fifo_rd_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        empty;
    logic [7:0]  r_data;
    logic        r_inc;
    logic        flush;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;
    int checks = 0;
    int failures = 0;

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK_COUNT(4), .TIMEOUT(16)) dut (
        .R_CLK(clk), .R_rst_n(rst_n), .Empty(empty), .R_Data(r_data), .R_inc(r_inc),
        .Flush(flush), .Out_Data(out_data), .Out_Keep(out_keep), .Out_Valid(out_valid),
        .Out_Ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop(input logic [7:0] b, input logic f);
        r_data = b;
        empty  = 1'b0;
        flush  = f;
        step();
        flush  = 1'b0;
    endtask

    task automatic handshake();
        empty     = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; empty = 1'b0; r_data = 8'h5A; flush = 1'b0; out_ready = 1'b0;
        step();
        checks++;
        if (r_inc !== 1'b0) begin failures++; $display("FAIL reset_rinc got=%b exp=0", r_inc); end
        checks++;
        if ({out_valid, out_keep, out_data} !== 37'h0) begin
            failures++; $display("FAIL reset_outputs got v=%b k=%b d=%h exp all 0", out_valid, out_keep, out_data);
        end
        rst_n = 1'b1; empty = 1'b1;
        step();
    endtask

    task automatic test_full_word();
        r_data = 8'h11; empty = 1'b0; #0;
        checks++;
        if (r_inc !== 1'b1) begin failures++; $display("FAIL full_rinc_collect got=%b exp=1", r_inc); end
        pop(8'h11, 0); pop(8'h22, 0); pop(8'h33, 0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL full_early_valid got=%b exp=0", out_valid); end
        pop(8'h44, 0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h44332211 || out_keep !== 4'b1111) begin
            failures++; $display("FAIL full_word got v=%b d=%h k=%b exp v=1 d=44332211 k=1111", out_valid, out_data, out_keep);
        end
        checks++;
        if (r_inc !== 1'b0) begin failures++; $display("FAIL full_rinc_hold got=%b exp=0", r_inc); end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_keep !== 4'b0) begin
            failures++; $display("FAIL full_after_hs got v=%b d=%h k=%b exp all 0", out_valid, out_data, out_keep);
        end
    endtask

    task automatic test_backpressure();
        pop(8'hA1, 0); pop(8'hA2, 0); pop(8'hA3, 0); pop(8'hA4, 0);
        empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'hA4A3A2A1 || out_keep !== 4'b1111 || r_inc !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall%0d got v=%b d=%h k=%b rinc=%b exp v=1 d=a4a3a2a1 k=1111 rinc=0",
                         i, out_valid, out_data, out_keep, r_inc);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || r_inc !== 1'b1) begin
            failures++; $display("FAIL bp_release got v=%b rinc=%b exp v=0 rinc=1", out_valid, r_inc);
        end
        empty = 1'b1;
    endtask

    task automatic test_timeout();
        pop(8'hAA, 0); pop(8'hBB, 0);
        empty = 1'b1;
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL to_early got v=%b exp=0", out_valid); end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000BBAA || out_keep !== 4'b0011) begin
            failures++; $display("FAIL to_word got v=%b d=%h k=%b exp v=1 d=0000bbaa k=0011", out_valid, out_data, out_keep);
        end
        handshake();
    endtask

    task automatic test_flush();
        pop(8'h01, 0); pop(8'h02, 0); pop(8'h03, 1);
        empty = 1'b1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00030201 || out_keep !== 4'b0111) begin
            failures++; $display("FAIL flush_pop got v=%b d=%h k=%b exp v=1 d=00030201 k=0111", out_valid, out_data, out_keep);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_keep !== 4'b0111) begin
            failures++; $display("FAIL flush_in_hold got v=%b k=%b exp v=1 k=0111", out_valid, out_keep);
        end
        handshake();
        pop(8'hC1, 0);
        empty = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h000000C1 || out_keep !== 4'b0001) begin
            failures++; $display("FAIL flush_idle got v=%b d=%h k=%b exp v=1 d=000000c1 k=0001", out_valid, out_data, out_keep);
        end
        handshake();
        pop(8'hD1, 0); pop(8'hD2, 0); pop(8'hD3, 0); pop(8'hD4, 1);
        empty = 1'b1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hD4D3D2D1 || out_keep !== 4'b1111) begin
            failures++; $display("FAIL flush_final got v=%b d=%h k=%b exp v=1 d=d4d3d2d1 k=1111", out_valid, out_data, out_keep);
        end
        handshake();
    endtask

    task automatic test_flush_empty();
        empty = 1'b1; flush = 1'b1;
        step(); step();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_keep !== 4'b0) begin
            failures++; $display("FAIL flush_empty got v=%b k=%b exp v=0 k=0000", out_valid, out_keep);
        end
        empty = 1'b0; #0;
        checks++;
        if (r_inc !== 1'b1) begin failures++; $display("FAIL flush_empty_collect got rinc=%b exp=1", r_inc); end
        empty = 1'b1;
    endtask

    task automatic test_reset_mid();
        pop(8'hDE, 0); pop(8'hAD, 0);
        rst_n = 1'b0; empty = 1'b0; #0;
        checks++;
        if (r_inc !== 1'b0) begin failures++; $display("FAIL rst_mid_rinc got=%b exp=0", r_inc); end
        step();
        rst_n = 1'b1; empty = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_keep !== 4'b0) begin
            failures++; $display("FAIL rst_mid_clear got v=%b d=%h k=%b exp all 0", out_valid, out_data, out_keep);
        end
        pop(8'h55, 0); pop(8'h66, 0); pop(8'h77, 0); pop(8'h88, 0);
        empty = 1'b1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h88776655 || out_keep !== 4'b1111) begin
            failures++; $display("FAIL rst_mid_word got v=%b d=%h k=%b exp v=1 d=88776655 k=1111", out_valid, out_data, out_keep);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_backpressure();
        test_timeout();
        test_flush();
        test_flush_empty();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
